// File: rtl/writeback_arbiter.sv
// writeback_arbiter: round-robin grant of the shared register/predicate write port to execution units.
// Define WB_ARB_FIXED_PRIORITY_EN for static lowest-index-wins priority instead of round-robin.
module writeback_arbiter #(
    parameter int NUM_UNITS       = 4,
    parameter int REG_BITS        = 4,
    parameter int PRED_REG_BITS   = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int COMPLEX_ALU_IDX = 1,
    parameter int FPU_IDX         = 2,
    parameter int MEM_UNIT_IDX    = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wb_hold,
    input  logic [NUM_UNITS-1:0]               req_valid,
    output logic [NUM_UNITS-1:0]               req_ready,
    input  logic [NUM_UNITS-1:0]               req_wr_reg,
    input  logic [NUM_UNITS*REG_BITS-1:0]      req_reg_addr,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0]    req_reg_data,
    input  logic [NUM_UNITS-1:0]               req_wr_pred,
    input  logic [NUM_UNITS*PRED_REG_BITS-1:0] req_pred_addr,
    input  logic [NUM_UNITS-1:0]               req_pred_data,
    output logic                               wr_reg,
    output logic [REG_BITS-1:0]                wr_reg_addr,
    output logic [DATA_WIDTH-1:0]              wr_reg_data,
    output logic                               wr_pred,
    output logic [PRED_REG_BITS-1:0]           wr_pred_addr,
    output logic                               wr_pred_data,
    output logic                               free_complex_alu,
    output logic                               free_fpu,
    output logic                               free_mem_unit
);
    localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    logic [IW-1:0] gidx;
    logic          found;
    logic          xfer;
`ifndef WB_ARB_FIXED_PRIORITY_EN
    logic [IW-1:0] last_grant;
`endif
    always_comb begin
        int idx;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
`ifdef WB_ARB_FIXED_PRIORITY_EN
            idx = k;
`else
            idx = (int'(last_grant) + 1 + k) % NUM_UNITS;
`endif
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx  = IW'(idx);
            end
        end
        xfer      = found && !reset && !wb_hold;
        req_ready = '0;
        if (xfer) req_ready[gidx] = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_reg           <= 1'b0;
            wr_reg_addr      <= '0;
            wr_reg_data      <= '0;
            wr_pred          <= 1'b0;
            wr_pred_addr     <= '0;
            wr_pred_data     <= 1'b0;
            free_complex_alu <= 1'b0;
            free_fpu         <= 1'b0;
            free_mem_unit    <= 1'b0;
`ifndef WB_ARB_FIXED_PRIORITY_EN
            last_grant       <= IW'(NUM_UNITS - 1);
`endif
        end else begin
            wr_reg           <= xfer && req_wr_reg[gidx];
            wr_pred          <= xfer && req_wr_pred[gidx];
            free_complex_alu <= xfer && gidx == IW'(COMPLEX_ALU_IDX);
            free_fpu         <= xfer && gidx == IW'(FPU_IDX);
            free_mem_unit    <= xfer && gidx == IW'(MEM_UNIT_IDX);
            if (xfer) begin
                wr_reg_addr  <= req_reg_addr[int'(gidx)*REG_BITS +: REG_BITS];
                wr_reg_data  <= req_reg_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
                wr_pred_addr <= req_pred_addr[int'(gidx)*PRED_REG_BITS +: PRED_REG_BITS];
                wr_pred_data <= req_pred_data[gidx];
`ifndef WB_ARB_FIXED_PRIORITY_EN
                last_grant   <= gidx;
`endif
            end
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed self-checking bench for writeback_arbiter.
module tb_writeback_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_hold = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [3:0]  req_wr_reg = '0;
    logic [15:0] req_reg_addr = '0;
    logic [127:0] req_reg_data = '0;
    logic [3:0]  req_wr_pred = '0;
    logic [7:0]  req_pred_addr = '0;
    logic [3:0]  req_pred_data = '0;
    logic        wr_reg, wr_pred, wr_pred_data;
    logic [3:0]  wr_reg_addr;
    logic [31:0] wr_reg_data;
    logic [1:0]  wr_pred_addr;
    logic        free_complex_alu, free_fpu, free_mem_unit;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    writeback_arbiter dut (
        .clk(clk), .reset(reset), .wb_hold(wb_hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wr_reg(req_wr_reg), .req_reg_addr(req_reg_addr), .req_reg_data(req_reg_data),
        .req_wr_pred(req_wr_pred), .req_pred_addr(req_pred_addr), .req_pred_data(req_pred_data),
        .wr_reg(wr_reg), .wr_reg_addr(wr_reg_addr), .wr_reg_data(wr_reg_data),
        .wr_pred(wr_pred), .wr_pred_addr(wr_pred_addr), .wr_pred_data(wr_pred_data),
        .free_complex_alu(free_complex_alu), .free_fpu(free_fpu), .free_mem_unit(free_mem_unit)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask
    initial begin
        int eg;
        tick();
        req_valid = 4'b1111;
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        tick();
        chk("rst_wr_reg", 32'(wr_reg), 0);
        chk("rst_addr", 32'(wr_reg_addr), 0);
        chk("rst_data", wr_reg_data, 0);
        chk("rst_frees", {29'd0, free_complex_alu, free_fpu, free_mem_unit}, 0);
        // T1: single request after reset
        reset = 1'b0;
        req_valid = 4'b0001;
        req_wr_reg[0] = 1'b1;
        req_reg_addr[3:0] = 4'd5;
        req_reg_data[31:0] = 32'hDEADBEEF;
        #1;
        chk("t1_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0000;
        chk("t1_wr_reg", 32'(wr_reg), 1);
        chk("t1_addr", 32'(wr_reg_addr), 5);
        chk("t1_data", wr_reg_data, 32'hDEADBEEF);
        chk("t1_frees", {29'd0, free_complex_alu, free_fpu, free_mem_unit}, 0);
        tick();
        chk("t1_wr_reg_low", 32'(wr_reg), 0);
        chk("t1_addr_hold", 32'(wr_reg_addr), 5);
        // T2: all units held valid, back-to-back grants
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_wr_reg[i] = 1'b1;
            req_reg_addr[i*4 +: 4] = 4'(i + 1);
            req_reg_data[i*32 +: 32] = 32'(100 + i);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
`ifdef WB_ARB_FIXED_PRIORITY_EN
            eg = 0;
`else
            eg = c % 4;
`endif
            #1;
            chk("t2_ready", 32'(req_ready), 32'(1) << eg);
            tick();
            chk("t2_wr_reg", 32'(wr_reg), 1);
            chk("t2_addr", 32'(wr_reg_addr), 32'(eg + 1));
            chk("t2_free_cplx", 32'(free_complex_alu), 32'(eg == 1));
            chk("t2_free_fpu", 32'(free_fpu), 32'(eg == 2));
        end
        req_valid = 4'b0000;
        tick();
        // T3: FPU writes GPR and predicate
        req_valid = 4'b0100;
        req_reg_addr[11:8] = 4'd9;
        req_wr_pred[2] = 1'b1;
        req_pred_addr[5:4] = 2'd2;
        req_pred_data[2] = 1'b1;
        #1;
        chk("t3_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        chk("t3_beat", {27'd0, wr_reg, wr_reg_addr}, {27'd0, 1'b1, 4'd9});
        chk("t3_pred", {28'd0, wr_pred, wr_pred_addr, wr_pred_data}, {28'd0, 1'b1, 2'd2, 1'b1});
        chk("t3_frees", {29'd0, free_complex_alu, free_fpu, free_mem_unit}, 32'b010);
        tick();
        chk("t3_after", {30'd0, wr_pred, free_fpu}, 0);
        // T4: memory store writes nothing but is still granted
        req_valid = 4'b1000;
        req_wr_reg[3] = 1'b0;
        req_wr_pred[3] = 1'b0;
        #1;
        chk("t4_ready", 32'(req_ready), 32'b1000);
        tick();
        req_valid = 4'b0000;
        chk("t4_strobes", {30'd0, wr_reg, wr_pred}, 0);
        chk("t4_frees", {29'd0, free_complex_alu, free_fpu, free_mem_unit}, 32'b001);
        // T5: hold blocks grants for three cycles
        req_valid = 4'b0110;
        wb_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t5_hold_ready", 32'(req_ready), 0);
            tick();
            chk("t5_hold_beat", {29'd0, wr_reg, free_complex_alu, free_fpu}, 0);
        end
        wb_hold = 1'b0;
        #1;
        chk("t5_rel_ready1", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0100;
        chk("t5_rel_beat1", {27'd0, wr_reg, wr_reg_addr}, {27'd0, 1'b1, 4'd2});
        chk("t5_rel_free1", 32'(free_complex_alu), 1);
        #1;
        chk("t5_rel_ready2", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        chk("t5_rel_beat2", {27'd0, wr_reg, wr_reg_addr}, {27'd0, 1'b1, 4'd9});
        // T6: reset right after a transfer drops the beat and restores unit0 priority
        req_valid = 4'b0010;
        #1;
        chk("t6_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b1111;
        reset = 1'b1;
        #1;
        chk("t6_rst_ready", 32'(req_ready), 0);
        tick();
        chk("t6_rst_out", {27'd0, wr_reg, wr_reg_addr}, 0);
        chk("t6_rst_data", wr_reg_data, 0);
        chk("t6_rst_free", 32'(free_complex_alu), 0);
        reset = 1'b0;
        #1;
        chk("t6_prio", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0000;
        chk("t6_beat", {27'd0, wr_reg, wr_reg_addr}, {27'd0, 1'b1, 4'd1});
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
